// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-unit bus between the CPU pipeline (master) and pipe_hazard_ctrl (slave).
// It carries the decoded ID-stage fields, the EX branch outcome, and the stall/flush/forward controls.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W     = 4,
  parameter int NUM_FWD_STAGES = 2,
  parameter int CNT_W          = 16
);
  localparam int FW = $clog2(NUM_FWD_STAGES + 1);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_rs_used;
  logic                  id_rt_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_wr;
  logic                  id_is_load;
  logic                  id_is_hlt;
  logic                  ex_branch_taken;
  logic                  stall_if;
  logic                  flush_id;
  logic                  bubble_ex;
  logic [FW-1:0]         fwd_a;
  logic [FW-1:0]         fwd_b;
  logic                  hlt;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_wr,
           id_is_load, id_is_hlt, ex_branch_taken,
    input  stall_if, flush_id, bubble_ex, fwd_a, fwd_b, hlt, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_wr,
           id_is_load, id_is_hlt, ex_branch_taken,
    output stall_if, flush_id, bubble_ex, fwd_a, fwd_b, hlt, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit: a scoreboard of in-flight destinations drives
// load-use stalls, branch flushes, N-deep forwarding selects and a drained halt.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W     = 4,
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_STAGE     = 2,
  parameter bit ZERO_REG       = 1'b1,
  parameter int CNT_W          = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int DEPTH = NUM_FWD_STAGES + 1;
  localparam int FW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DEPTH);
  localparam logic [CW-1:0] DRAIN_ONE  = CW'(1);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  logic                  v_r  [DEPTH];
  logic                  wr_r [DEPTH];
  logic                  ld_r [DEPTH];
  logic [REG_ADDR_W-1:0] rd_r [DEPTH];
  logic [REG_ADDR_W-1:0] rs0_r;
  logic [REG_ADDR_W-1:0] rt0_r;
  logic                  rs0_u_r;
  logic                  rt0_u_r;

  state_t           state_r;
  logic [CW-1:0]    drain_cnt_r;
  logic             hlt_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic          lu_s;
  logic          lu_stall_s;
  logic          hlt_accept_s;
  logic          capture_s;
  logic          stall_s;
  logic          flush_s;
  logic          bubble_s;
  logic [FW-1:0] fwd_a_s;
  logic [FW-1:0] fwd_b_s;

  function automatic logic reg_hit(input logic v, input logic wr,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] r);
    reg_hit = v & wr & (rd == r) & (~ZERO_REG | (r != {REG_ADDR_W{1'b0}}));
  endfunction

  // Load-use detection: a load too young to forward its data to the ID reader.
  always_comb begin
    lu_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < LOAD_STAGE - 1) begin
        lu_s = lu_s | (ld_r[k] &
               ((bus.id_rs_used & reg_hit(v_r[k], wr_r[k], rd_r[k], bus.id_rs)) |
                (bus.id_rt_used & reg_hit(v_r[k], wr_r[k], rd_r[k], bus.id_rt))));
      end else begin
        lu_s = lu_s;
      end
    end
    lu_s = lu_s & bus.id_valid;
  end

  // Forward selects for the EX operands; scanning oldest-first lets the youngest producer win.
  always_comb begin
    fwd_a_s = {FW{1'b0}};
    fwd_b_s = {FW{1'b0}};
    for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
      if (v_r[0] && rs0_u_r && reg_hit(v_r[k], wr_r[k], rd_r[k], rs0_r)) begin
        fwd_a_s = FW'(k);
      end else begin
        fwd_a_s = fwd_a_s;
      end
      if (v_r[0] && rt0_u_r && reg_hit(v_r[k], wr_r[k], rd_r[k], rt0_r)) begin
        fwd_b_s = FW'(k);
      end else begin
        fwd_b_s = fwd_b_s;
      end
    end
  end

  // Pipeline controls; a taken branch takes priority over a load-use stall.
  always_comb begin
    stall_s  = 1'b0;
    flush_s  = 1'b0;
    bubble_s = 1'b0;
    case (state_r)
      RUN: begin
        if (bus.ex_branch_taken) begin
          flush_s  = 1'b1;
          bubble_s = 1'b1;
        end else if (lu_s) begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
        end else begin
          stall_s  = 1'b0;
          bubble_s = 1'b0;
        end
      end
      DRAIN, HALTED: begin
        stall_s  = 1'b1;
        bubble_s = 1'b1;
      end
      default: begin
        stall_s  = 1'b1;
        bubble_s = 1'b1;
      end
    endcase
  end

  assign lu_stall_s   = (state_r == RUN) & ~bus.ex_branch_taken & lu_s;
  assign hlt_accept_s = (state_r == RUN) & bus.id_valid & bus.id_is_hlt &
                        ~bus.ex_branch_taken & ~lu_s;
  assign capture_s    = bus.id_valid & ~stall_s & ~bubble_s;

  // Scoreboard shift in lock-step with ID/EX, EX/MEM and MEM/WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_r[k]  <= 1'b0;
        wr_r[k] <= 1'b0;
        ld_r[k] <= 1'b0;
        rd_r[k] <= {REG_ADDR_W{1'b0}};
      end
      rs0_r   <= {REG_ADDR_W{1'b0}};
      rt0_r   <= {REG_ADDR_W{1'b0}};
      rs0_u_r <= 1'b0;
      rt0_u_r <= 1'b0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        v_r[k]  <= v_r[k-1];
        wr_r[k] <= wr_r[k-1];
        ld_r[k] <= ld_r[k-1];
        rd_r[k] <= rd_r[k-1];
      end
      v_r[0]  <= capture_s;
      wr_r[0] <= capture_s & bus.id_wr & ~bus.id_is_hlt;
      ld_r[0] <= capture_s & bus.id_is_load;
      rd_r[0] <= bus.id_rd;
      rs0_r   <= bus.id_rs;
      rt0_r   <= bus.id_rt;
      rs0_u_r <= capture_s & bus.id_rs_used;
      rt0_u_r <= capture_s & bus.id_rt_used;
    end
  end

  // Halt FSM: drain every in-flight instruction past WB before reporting halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      drain_cnt_r <= {CW{1'b0}};
      hlt_r       <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (hlt_accept_s) begin
            state_r     <= DRAIN;
            drain_cnt_r <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          drain_cnt_r <= drain_cnt_r - DRAIN_ONE;
          if (drain_cnt_r == DRAIN_ONE) begin
            state_r <= HALTED;
            hlt_r   <= 1'b1;
          end
        end
        HALTED: begin
          hlt_r <= 1'b1;
        end
        default: begin
          state_r     <= RUN;
          drain_cnt_r <= {CW{1'b0}};
          hlt_r       <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles lost to load-use stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (lu_stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.stall_if  = stall_s;
  assign bus.flush_id  = flush_s;
  assign bus.bubble_ex = bubble_s;
  assign bus.fwd_a     = fwd_a_s;
  assign bus.fwd_b     = fwd_b_s;
  assign bus.hlt       = hlt_r;
  assign bus.stall_cnt = stall_cnt_r;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instruction sequences are fed into ID one per cycle
// and the controls are compared against hand-worked pipeline timing.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(4), .NUM_FWD_STAGES(2), .CNT_W(16)) bus ();

  pipe_hazard_ctrl #(
    .REG_ADDR_W(4), .NUM_FWD_STAGES(2), .LOAD_STAGE(2), .ZERO_REG(1'b1), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic s, input logic f, input logic b);
    chk({tag, ".stall_if"}, 32'(bus.stall_if), 32'(s));
    chk({tag, ".flush_id"}, 32'(bus.flush_id), 32'(f));
    chk({tag, ".bubble_ex"}, 32'(bus.bubble_ex), 32'(b));
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
    chk({tag, ".fwd_a"}, 32'(bus.fwd_a), 32'(a));
    chk({tag, ".fwd_b"}, 32'(bus.fwd_b), 32'(b));
  endtask

  // Present one ID-stage instruction at the falling edge; checks follow 1ns later.
  task automatic put(input logic v, input logic [3:0] rd, input logic wr, input logic ld,
                     input logic [3:0] rs, input logic rsu, input logic [3:0] rt,
                     input logic rtu, input logic hl, input logic br);
    @(negedge clk);
    bus.id_valid        = v;
    bus.id_rd           = rd;
    bus.id_wr           = wr;
    bus.id_is_load      = ld;
    bus.id_rs           = rs;
    bus.id_rs_used      = rsu;
    bus.id_rt           = rt;
    bus.id_rt_used      = rtu;
    bus.id_is_hlt       = hl;
    bus.ex_branch_taken = br;
    #1;
  endtask

  task automatic alu(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
    put(1'b1, rd, 1'b1, 1'b0, rs, 1'b1, rt, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [3:0] rd, input logic [3:0] rs);
    put(1'b1, rd, 1'b1, 1'b1, rs, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nop();
    put(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic halt_i();
    put(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    put(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk_fwd("reset", 2'd0, 2'd0);
    chk("reset.hlt", 32'(bus.hlt), 32'd0);
    chk("reset.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // LW r3 ; ADD r4,r3,r5 -> one bubble, then forward from WB
    lw(4'd3, 4'd2);
    chk_ctl("lw_in_id", 1'b0, 1'b0, 1'b0);
    alu(4'd4, 4'd3, 4'd5);
    chk_ctl("lu_stall", 1'b1, 1'b0, 1'b1);
    chk("lu_stall.cnt_before", 32'(bus.stall_cnt), 32'd0);
    alu(4'd4, 4'd3, 4'd5);
    chk_ctl("lu_release", 1'b0, 1'b0, 1'b0);
    chk("lu_release.cnt", 32'(bus.stall_cnt), 32'd1);
    nop();
    chk_fwd("lw_fwd_wb", 2'd2, 2'd0);

    // Back-to-back ALU dependency -> MEM forward on both operands
    alu(4'd1, 4'd2, 4'd3);
    alu(4'd2, 4'd1, 4'd1);
    chk_ctl("raw_nostall", 1'b0, 1'b0, 1'b0);
    nop();
    chk_fwd("fwd_mem", 2'd1, 2'd1);

    // One NOP gap -> WB forward
    alu(4'd1, 4'd2, 4'd3);
    nop();
    alu(4'd2, 4'd1, 4'd1);
    nop();
    chk_fwd("fwd_wb", 2'd2, 2'd2);

    // Two producers of r1 in flight -> the younger one wins
    alu(4'd1, 4'd2, 4'd3);
    alu(4'd1, 4'd4, 4'd5);
    alu(4'd6, 4'd1, 4'd1);
    nop();
    chk_fwd("youngest", 2'd1, 2'd1);

    // Register 0 never creates a dependency
    lw(4'd0, 4'd2);
    alu(4'd7, 4'd0, 4'd0);
    chk_ctl("zero_lu", 1'b0, 1'b0, 1'b0);
    nop();
    chk_fwd("zero_lw_fwd", 2'd0, 2'd0);
    alu(4'd0, 4'd2, 4'd3);
    alu(4'd7, 4'd0, 4'd0);
    nop();
    chk_fwd("zero_add_fwd", 2'd0, 2'd0);
    chk("zero.cnt", 32'(bus.stall_cnt), 32'd1);

    // Taken branch while a load-use pair sits in EX/ID
    lw(4'd3, 4'd2);
    put(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1);
    chk_ctl("branch", 1'b0, 1'b1, 1'b1);
    nop();
    chk_ctl("branch_after", 1'b0, 1'b0, 1'b0);
    chk("branch.cnt", 32'(bus.stall_cnt), 32'd1);

    // HLT after ADD r1 -> 3 drain cycles, then halted and held
    alu(4'd1, 4'd2, 4'd3);
    halt_i();
    chk_ctl("hlt_accept", 1'b0, 1'b0, 1'b0);
    nop();
    chk_ctl("drain1", 1'b1, 1'b0, 1'b1);
    chk("drain1.hlt", 32'(bus.hlt), 32'd0);
    nop();
    chk_ctl("drain2", 1'b1, 1'b0, 1'b1);
    chk("drain2.hlt", 32'(bus.hlt), 32'd0);
    nop();
    chk_ctl("drain3", 1'b1, 1'b0, 1'b1);
    chk("drain3.hlt", 32'(bus.hlt), 32'd0);
    nop();
    chk_ctl("halted", 1'b1, 1'b0, 1'b1);
    chk("halted.hlt", 32'(bus.hlt), 32'd1);
    nop();
    chk("halted_hold.hlt", 32'(bus.hlt), 32'd1);
    chk("halted.cnt", 32'(bus.stall_cnt), 32'd1);

    // Asynchronous reset while halted
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_halted.hlt", 32'(bus.hlt), 32'd0);
    chk_ctl("rst_halted", 1'b0, 1'b0, 1'b0);
    chk("rst_halted.cnt", 32'(bus.stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // HLT reading a load result: stall resolves first, then HLT is accepted
    lw(4'd3, 4'd2);
    put(1'b1, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    chk_ctl("lu_hlt", 1'b1, 1'b0, 1'b1);
    put(1'b1, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    chk_ctl("hlt_after_lu", 1'b0, 1'b0, 1'b0);
    chk("hlt_after_lu.cnt", 32'(bus.stall_cnt), 32'd1);
    nop();
    chk_ctl("drain_b1", 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-drain returns to RUN immediately
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_ctl("rst_drain", 1'b0, 1'b0, 1'b0);
    chk("rst_drain.hlt", 32'(bus.hlt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nop();
    chk_ctl("run_after_rst", 1'b0, 1'b0, 1'b0);
    nop();
    chk_ctl("run_after_rst2", 1'b0, 1'b0, 1'b0);
    chk("run_after_rst.hlt", 32'(bus.hlt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
